// File: rtl/muldiv_unit_if.sv
// Request/result bundle for the multiply/divide unit: request strobe and
// operands in, status pulses and the architectural HI/LO registers out.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One radix-2 step per enabled cycle; signed ops run on magnitudes and
// the signs are restored in a final fix-up cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; MTHI/MTLO are handled here in one edge
// CALC   | WIDTH shift-add (multiply) or restoring shift-subtract steps
// FIX    | sign correction and commit to HI/LO, or divide-by-zero report
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  muldiv_unit_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;    // partial product high half / running remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] opd_b;     // multiplicand / divisor magnitude
  logic             is_div;
  logic             neg_q;     // product or quotient must be negated at commit
  logic             neg_r;     // remainder must be negated at commit
  logic             dbz_pend;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;

  logic               sgn_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes at accept, one iteration step, and sign fix-up values.
  always_comb begin
    sgn_op    = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    abs_a     = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opd_b};
    // The true difference is below 2**WIDTH whenever it is used, so the
    // truncated subtraction is exact.
    div_sub   = div_shift[WIDTH-1:0] - opd_b;
    prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quot_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix   = neg_r ? -acc_hi : acc_hi;
  end

  // Sequencer, datapath and HI/LO; reset outranks the enable, the enable stalls all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opd_b    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz_pend <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (clk_enable) begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                acc_hi <= '0;
                acc_lo <= abs_a;
                opd_b  <= abs_b;
                is_div <= bus.op[1];
                neg_q  <= sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r  <= sgn_op && bus.a[WIDTH-1];
                cnt    <= '0;
                if (bus.op[1] && (bus.b == '0)) begin
                  dbz_pend <= 1'b1;
                  state    <= S_FIX;
                end else begin
                  dbz_pend <= 1'b0;
                  state    <= S_CALC;
                end
              end
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (is_div) begin
            acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (dbz_pend) begin
            dbz_q <= 1'b1;
          end else if (is_div) begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected HI/LO/flag results are
// queued when a request is issued and compared when done is seen.
module tb_muldiv_unit;
  localparam int W = 32;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic reset;
  logic clk_enable;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic; returns {dbz, hi, lo}.
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] ch,
                                         input logic [31:0] cl);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: begin p = sa * sb; return {1'b0, p}; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      3'd2: begin
        if (b == 0) return {1'b1, ch, cl};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {1'b1, ch, cl};
        return {1'b0, a % b, a / b};
      end
      default: return {1'b0, ch, cl};
    endcase
  endfunction

  task automatic expect_res(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                            input logic dbz);
    exp_t e;
    e.tag = tag; e.hi = hi; e.lo = lo; e.dbz = dbz;
    sb_q.push_back(e);
  endtask

  // Presents a request for exactly one rising edge (E0); returns at E0+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Waits for done, optionally stalling and poking start while busy, then
  // checks latency, busy duration and the queued result.
  task automatic wait_done(input int exp_lat, input int exp_busy, input int stall_at,
                           input int stall_len, input int poke_at);
    int   n;
    int   bcnt;
    logic seen;
    exp_t e;
    n = 0;
    seen = 1'b0;
    bcnt = int'(bus.busy);
    while (n < 200) begin
      if (n == stall_at) clk_enable = 1'b0;
      if (n == stall_at + stall_len) clk_enable = 1'b1;
      if (n == poke_at) begin
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      n++;
      #1;
      if (n == poke_at + 1) check_eq("ignore_start_hi", {32'b0, bus.hi}, {32'b0, model_hi});
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      bcnt += int'(bus.busy);
    end
    clk_enable = 1'b1;
    bus.start = 1'b0;
    if (!seen) check_eq("done_timeout", 64'd0, 64'd1);
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    if (seen) begin
      check_eq({e.tag, "_lat"}, 64'(n), 64'(exp_lat));
      if (exp_busy >= 0) check_eq({e.tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
      check_eq({e.tag, "_hi"}, {32'b0, bus.hi}, {32'b0, e.hi});
      check_eq({e.tag, "_lo"}, {32'b0, bus.lo}, {32'b0, e.lo});
      check_eq({e.tag, "_dbz"}, {63'b0, bus.div_by_zero}, {63'b0, e.dbz});
    end
    model_hi = e.hi;
    model_lo = e.lo;
    @(posedge clk);
    #1;
    check_eq({e.tag, "_done_fall"}, {62'b0, bus.done, bus.div_by_zero}, 64'd0);
  endtask

  task automatic run_ref(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    logic [64:0] r;
    r = ref_op(op, a, b, model_hi, model_lo);
    expect_res(tag, r[63:32], r[31:0], r[64]);
    issue(op, a, b);
    if (r[64]) wait_done(1, -1, -1, 0, -1);
    else wait_done(W + 1, W + 1, -1, 0, -1);
  endtask

  initial begin
    int dcnt;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    clk_enable = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_hi", {32'b0, bus.hi}, 64'd0);
    check_eq("reset_lo", {32'b0, bus.lo}, 64'd0);
    check_eq("reset_flags", {61'b0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    reset = 1'b1;
    model_hi = '0;
    model_lo = '0;

    issue(3'b100, 32'h1234, 32'h0);
    check_eq("mthi_hi", {32'b0, bus.hi}, 64'h1234);
    check_eq("mthi_busy", {63'b0, bus.busy}, 64'd0);
    issue(3'b101, 32'h5678, 32'h0);
    check_eq("mtlo_lo", {32'b0, bus.lo}, 64'h5678);
    check_eq("mtlo_hi_kept", {32'b0, bus.hi}, 64'h1234);
    check_eq("mtlo_done", {63'b0, bus.done}, 64'd0);
    model_hi = 32'h1234;
    model_lo = 32'h5678;

    expect_res("div_by_zero", 32'h1234, 32'h5678, 1'b1);
    issue(3'b010, 32'd9, 32'd0);
    wait_done(1, -1, -1, 0, -1);

    expect_res("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue(3'b000, 32'hFFFF_FFFD, 32'd5);
    wait_done(33, 33, -1, 0, -1);

    expect_res("divu_100_7", 32'h2, 32'hE, 1'b0);
    issue(3'b011, 32'd100, 32'd7);
    wait_done(33, 33, -1, 0, -1);

    expect_res("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done(33, 33, -1, 0, -1);

    expect_res("div_minneg_m1", 32'h0, 32'h8000_0000, 1'b0);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(33, 33, -1, 0, -1);

    expect_res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(33, 33, -1, 0, -1);

    issue(3'b110, 32'hAAAA_AAAA, 32'h5);
    check_eq("reserved_busy", {63'b0, bus.busy}, 64'd0);
    check_eq("reserved_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});
    @(posedge clk);
    #1;
    check_eq("reserved_done", {63'b0, bus.done}, 64'd0);

    begin
      logic [64:0] r;
      r = ref_op(3'b000, 32'h0001_2345, 32'hFFFF_0F0F, model_hi, model_lo);
      expect_res("mult_stall", r[63:32], r[31:0], 1'b0);
      issue(3'b000, 32'h0001_2345, 32'hFFFF_0F0F);
      wait_done(38, 38, 10, 5, 20);
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_ref($sformatf("rand%0d_op%0d", i, op), op, a, b);
    end

    issue(3'b011, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_eq("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("abort_flags", {61'b0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      dcnt += int'(bus.done);
    end
    check_eq("abort_no_done", 64'(dcnt), 64'd0);

    expect_res("multu_6x7", 32'h0, 32'd42, 1'b0);
    issue(3'b001, 32'd6, 32'd7);
    wait_done(33, 33, -1, 0, -1);

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width and HI/LO register width (legal: 8..64, even).
REQ-002 Parameter: CNT_W, $clog2(WIDTH)+1, iteration counter width.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-low reset; reset is applied when reset=0 at a rising clk edge.
REQ-005 Port: clk_enable  in  1  when 0, all internal state and outputs hold their values (stall).
REQ-006 Port: start  in  1  request strobe, sampled at a rising edge.
REQ-007 Port: op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-008 Port: a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
REQ-009 Port: b  in  WIDTH  rt operand (multiplier / divisor).
REQ-010 Port: busy  out  1  high while a MULT/DIV operation is in progress.
REQ-011 Port: done  out  1  one-cycle pulse when a result is committed to HI/LO.
REQ-012 Port: div_by_zero  out  1  one-cycle pulse coincident with done for DIV/DIVU with b=0.
REQ-013 Port: hi  out  WIDTH  architectural HI register.
REQ-014 Port: lo  out  WIDTH  architectural LO register.

Function
REQ-015 FSM states: IDLE, CALC, FIX; all transitions require clk_enable=1.
REQ-016 IDLE: start=1 with op MULT/MULTU/DIV/DIVU -> latch |a|, |b| (signed ops) or raw a, b (unsigned ops); latch result signs; clear counter; go to CALC.
REQ-017 IDLE: start=1 with op=MTHI writes hi<=a; with op=MTLO writes lo<=a, at the accepting edge; stay in IDLE; no busy, no done.
REQ-018 IDLE: start=1 with a reserved op is ignored and causes no state change.
REQ-019 CALC: exactly one radix-2 step per enabled cycle (shift-add for multiply, restoring shift-subtract for divide); leave for FIX after exactly WIDTH steps.
REQ-020 FIX: apply sign correction; commit the 2*WIDTH product as {hi,lo}, or quotient->lo and remainder->hi; go to IDLE; done=1 in the following cycle.
REQ-021 Latency: with an accept at edge E0 and clk_enable held high, hi/lo update and done rises at edge E(WIDTH+1); done falls at E(WIDTH+2).
REQ-022 busy=1 from E0 until E(WIDTH+1), i.e. for exactly WIDTH+1 cycles; busy=0 in IDLE.
REQ-023 start while busy=1 is ignored; operands, op and the in-flight result are unaffected.
REQ-024 Signed divide truncates toward zero; remainder takes the dividend's sign.
REQ-025 DIV of the most-negative value by -1 yields lo=most-negative value and hi=0, with no flag.
REQ-026 DIV/DIVU with b=0: skip CALC; at E1 go to IDLE; hi and lo are unchanged; done=1 and div_by_zero=1 for one cycle.
REQ-027 MULTU/DIVU treat operands as unsigned; MULT/DIV treat them as two's complement; no overflow flag exists.
REQ-028 clk_enable=0 at any point freezes the FSM, counter, datapath, hi, lo, busy and done; a pending done pulse is extended until the next enabled edge.
REQ-029 hi and lo change only via REQ-017, REQ-020 or reset.

Reset
REQ-030 reset=0 at an edge forces IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, and clears the counter; this has priority over start and over clk_enable.
REQ-031 reset mid-operation aborts the operation; no done pulse follows, and the next start behaves as from power-up.

Verification
REQ-032 WIDTH=32, MULT a=0xFFFFFFFD, b=5 -> done at E33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 33 cycles.
REQ-033 DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002; DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 Preload via MTHI 0x1234, MTLO 0x5678, then DIV a=9, b=0 -> done and div_by_zero at E1; hi=0x1234, lo=0x5678.
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 MULT started, clk_enable=0 for 5 cycles mid-CALC, and start pulsed while busy -> done at E38 with the original product; the extra start is ignored.
REQ-037 reset=0 at E10 of a DIVU -> all outputs 0 at the next cycle, no done; a new MULTU 6*7 -> lo=42, hi=0.
